// File: rtl/gray_code_unit.sv
// Gray-code engine: up/down Gray counter plus Gray-to-binary decoder with single-step checker.
// Latency: counter outputs register on the step edge; decoder/checker outputs 1 cycle after gin_vld.
// Backpressure: none; en and gin_vld are accepted every cycle, nothing stalls.
module gray_code_unit #(
  parameter int WIDTH    = 4,
  parameter int SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt_bin,
  output logic [WIDTH-1:0] cnt_gray,
  output logic             wrap_p,
  output logic             at_limit,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gin_vld,
  output logic [WIDTH-1:0] dec_bin,
  output logic             dec_vld,
  output logic             step_err
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Counter state
  logic [WIDTH-1:0] cnt_bin_q,  cnt_bin_d;
  logic [WIDTH-1:0] cnt_gray_q, cnt_gray_d;
  logic             wrap_p_q,   wrap_p_d;

  // Decoder / checker state
  logic [WIDTH-1:0] dec_bin_q,   dec_bin_d;
  logic             dec_vld_q,   dec_vld_d;
  logic             step_err_q,  step_err_d;
  logic [WIDTH-1:0] last_gray_q, last_gray_d;
  logic             hist_q,      hist_d;

  logic [WIDTH-1:0] dec_calc;
  logic [WIDTH-1:0] gray_diff;
  logic             multi_bit;

  // Next counter value: load beats en; limits either wrap (with pulse) or saturate.
  // Gray is derived from the next binary value so both register on the same edge.
  always_comb begin
    cnt_bin_d = cnt_bin_q;
    wrap_p_d  = 1'b0;
    if (load) begin
      cnt_bin_d = load_val;
    end else if (en) begin
      if (up_dn) begin
        if (cnt_bin_q != CNT_MAX) begin
          cnt_bin_d = cnt_bin_q + CNT_ONE;
        end else if (SAT_MODE == 0) begin
          cnt_bin_d = CNT_ZERO;
          wrap_p_d  = 1'b1;
        end
      end else begin
        if (cnt_bin_q != CNT_ZERO) begin
          cnt_bin_d = cnt_bin_q - CNT_ONE;
        end else if (SAT_MODE == 0) begin
          cnt_bin_d = CNT_MAX;
          wrap_p_d  = 1'b1;
        end
      end
    end
    cnt_gray_d = cnt_bin_d ^ (cnt_bin_d >> 1);
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    dec_calc = gray_in;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec_calc[i] = dec_calc[i+1] ^ gray_in[i];
    end
  end

  // More than one bit changed iff the difference word is not zero and not a power of two.
  always_comb begin
    gray_diff = gray_in ^ last_gray_q;
    multi_bit = |(gray_diff & (gray_diff - CNT_ONE));
  end

  // Decoder next state: a valid sample updates output and history; idle cycles keep history.
  always_comb begin
    dec_bin_d   = dec_bin_q;
    dec_vld_d   = 1'b0;
    step_err_d  = 1'b0;
    last_gray_d = last_gray_q;
    hist_d      = hist_q;
    if (gin_vld) begin
      dec_bin_d   = dec_calc;
      dec_vld_d   = 1'b1;
      step_err_d  = hist_q && multi_bit;
      last_gray_d = gray_in;
      hist_d      = 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_bin_q  <= '0;
      cnt_gray_q <= '0;
      wrap_p_q   <= 1'b0;
    end else begin
      cnt_bin_q  <= cnt_bin_d;
      cnt_gray_q <= cnt_gray_d;
      wrap_p_q   <= wrap_p_d;
    end
  end

  // Decoder / checker registers; reset empties the history so the next sample is unflagged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_bin_q   <= '0;
      dec_vld_q   <= 1'b0;
      step_err_q  <= 1'b0;
      last_gray_q <= '0;
      hist_q      <= 1'b0;
    end else begin
      dec_bin_q   <= dec_bin_d;
      dec_vld_q   <= dec_vld_d;
      step_err_q  <= step_err_d;
      last_gray_q <= last_gray_d;
      hist_q      <= hist_d;
    end
  end

  assign cnt_bin  = cnt_bin_q;
  assign cnt_gray = cnt_gray_q;
  assign wrap_p   = wrap_p_q;
  assign at_limit = up_dn ? (cnt_bin_q == CNT_MAX) : (cnt_bin_q == CNT_ZERO);
  assign dec_bin  = dec_bin_q;
  assign dec_vld  = dec_vld_q;
  assign step_err = step_err_q;

endmodule

// File: tb/tb_gray_code_unit.sv
// Bench for gray_code_unit: wrap-mode and saturate-mode instances driven from shared inputs.
// Per-cycle vector table for counting/decoding, hand sequences for saturation and async reset.
// Inputs change 1 time unit after the rising edge; outputs sampled at that same point.
module tb_gray_code_unit;

  logic       clk;
  logic       rst_n;
  logic       en, up_dn, load, gin_vld;
  logic [3:0] load_val, gray_in;

  logic [3:0] cnt_bin_w, cnt_gray_w, dec_bin_w;
  logic       wrap_p_w, at_limit_w, dec_vld_w, step_err_w;
  logic [3:0] cnt_bin_s, cnt_gray_s, dec_bin_s;
  logic       wrap_p_s, at_limit_s, dec_vld_s, step_err_s;

  int checks   = 0;
  int failures = 0;

  gray_code_unit #(.WIDTH(4), .SAT_MODE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .cnt_bin(cnt_bin_w), .cnt_gray(cnt_gray_w), .wrap_p(wrap_p_w), .at_limit(at_limit_w),
    .gray_in(gray_in), .gin_vld(gin_vld), .dec_bin(dec_bin_w), .dec_vld(dec_vld_w),
    .step_err(step_err_w)
  );

  gray_code_unit #(.WIDTH(4), .SAT_MODE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .cnt_bin(cnt_bin_s), .cnt_gray(cnt_gray_s), .wrap_p(wrap_p_s), .at_limit(at_limit_s),
    .gray_in(gray_in), .gin_vld(gin_vld), .dec_bin(dec_bin_s), .dec_vld(dec_vld_s),
    .step_err(step_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] gray_in;
    logic       gin_vld;
    logic [3:0] cnt_bin;
    logic [3:0] cnt_gray;
    logic       wrap_p;
    logic       at_limit;
    logic [3:0] dec_bin;
    logic       dec_vld;
    logic       step_err;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'h0; gray_in = 4'h0; gin_vld = 1'b0;
  endtask

  initial begin
    logic [3:0] prev_gray;

    // en up ld lv  gi  gv | cb   cg   wp  al  db   dv  se
    vecs[0]  = '{1,1,0,4'h0,4'h0,1, 4'h1,4'h1,0,0, 4'h0,1,0};
    vecs[1]  = '{1,1,0,4'h0,4'h1,1, 4'h2,4'h3,0,0, 4'h1,1,0};
    vecs[2]  = '{1,1,0,4'h0,4'h3,1, 4'h3,4'h2,0,0, 4'h2,1,0};
    vecs[3]  = '{1,1,0,4'h0,4'hF,1, 4'h4,4'h6,0,0, 4'hA,1,1};
    vecs[4]  = '{1,1,0,4'h0,4'h0,0, 4'h5,4'h7,0,0, 4'hA,0,0};
    vecs[5]  = '{1,1,0,4'h0,4'hE,1, 4'h6,4'h5,0,0, 4'hB,1,0};
    vecs[6]  = '{1,1,0,4'h0,4'h0,1, 4'h7,4'h4,0,0, 4'h0,1,1};
    vecs[7]  = '{1,1,0,4'h0,4'h0,0, 4'h8,4'hC,0,0, 4'h0,0,0};
    vecs[8]  = '{1,1,0,4'h0,4'h0,0, 4'h9,4'hD,0,0, 4'h0,0,0};
    vecs[9]  = '{1,1,0,4'h0,4'h0,0, 4'hA,4'hF,0,0, 4'h0,0,0};
    vecs[10] = '{1,1,0,4'h0,4'h0,0, 4'hB,4'hE,0,0, 4'h0,0,0};
    vecs[11] = '{1,1,0,4'h0,4'h0,0, 4'hC,4'hA,0,0, 4'h0,0,0};
    vecs[12] = '{1,1,0,4'h0,4'h0,0, 4'hD,4'hB,0,0, 4'h0,0,0};
    vecs[13] = '{1,1,0,4'h0,4'h0,0, 4'hE,4'h9,0,0, 4'h0,0,0};
    vecs[14] = '{1,1,0,4'h0,4'h0,0, 4'hF,4'h8,0,1, 4'h0,0,0};
    vecs[15] = '{1,1,0,4'h0,4'h0,0, 4'h0,4'h0,1,0, 4'h0,0,0};
    vecs[16] = '{1,0,0,4'h0,4'h0,0, 4'hF,4'h8,1,0, 4'h0,0,0};
    vecs[17] = '{0,0,0,4'h0,4'h0,0, 4'hF,4'h8,0,0, 4'h0,0,0};
    vecs[18] = '{1,0,1,4'hA,4'h0,0, 4'hA,4'hF,0,0, 4'h0,0,0};
    vecs[19] = '{1,1,0,4'h0,4'h0,0, 4'hB,4'hE,0,0, 4'h0,0,0};

    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_cnt_bin",  cnt_bin_w,  4'h0);
    chk("rst_cnt_gray", cnt_gray_w, 4'h0);
    chk("rst_wrap_p",   {3'b0, wrap_p_w},   4'h0);
    chk("rst_at_limit", {3'b0, at_limit_w}, 4'h0);
    chk("rst_dec_bin",  dec_bin_w,  4'h0);
    chk("rst_dec_vld",  {3'b0, dec_vld_w},  4'h0);
    chk("rst_step_err", {3'b0, step_err_w}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table: 16-step up count with wrap, concurrent decoder stream, down-wrap, load-wins-over-en
    prev_gray = cnt_gray_w;
    for (int i = 0; i < 20; i++) begin
      en = vecs[i].en; up_dn = vecs[i].up_dn; load = vecs[i].load;
      load_val = vecs[i].load_val; gray_in = vecs[i].gray_in; gin_vld = vecs[i].gin_vld;
      tick();
      chk($sformatf("v%0d_cnt_bin", i),  cnt_bin_w,  vecs[i].cnt_bin);
      chk($sformatf("v%0d_cnt_gray", i), cnt_gray_w, vecs[i].cnt_gray);
      chk($sformatf("v%0d_wrap_p", i),   {3'b0, wrap_p_w},   {3'b0, vecs[i].wrap_p});
      chk($sformatf("v%0d_at_limit", i), {3'b0, at_limit_w}, {3'b0, vecs[i].at_limit});
      chk($sformatf("v%0d_dec_bin", i),  dec_bin_w,  vecs[i].dec_bin);
      chk($sformatf("v%0d_dec_vld", i),  {3'b0, dec_vld_w},  {3'b0, vecs[i].dec_vld});
      chk($sformatf("v%0d_step_err", i), {3'b0, step_err_w}, {3'b0, vecs[i].step_err});
      if (vecs[i].en && !vecs[i].load)
        chk($sformatf("v%0d_gray_1bit", i), 4'($countones(cnt_gray_w ^ prev_gray)), 4'd1);
      prev_gray = cnt_gray_w;
    end

    // Saturate mode: hold at all-ones going up, then step down once
    idle_inputs();
    load = 1'b1; load_val = 4'hF;
    tick();
    chk("sat_load", cnt_bin_s, 4'hF);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("sat_hold%0d_cnt", k),   cnt_bin_s,  4'hF);
      chk($sformatf("sat_hold%0d_gray", k),  cnt_gray_s, 4'h8);
      chk($sformatf("sat_hold%0d_limit", k), {3'b0, at_limit_s}, 4'h1);
      chk($sformatf("sat_hold%0d_wrap", k),  {3'b0, wrap_p_s},   4'h0);
    end
    // Wrap instance wrapped on the first of those steps and is now at 2
    chk("wrap_cmp_cnt", cnt_bin_w, 4'h2);
    up_dn = 1'b0;
    tick();
    chk("sat_down_cnt",  cnt_bin_s,  4'hE);
    chk("sat_down_gray", cnt_gray_s, 4'h9);
    // Saturate at zero going down
    en = 1'b0; load = 1'b1; load_val = 4'h0;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    chk("sat_zero_cnt",  cnt_bin_s, 4'h0);
    chk("sat_zero_wrap", {3'b0, wrap_p_s}, 4'h0);
    chk("sat_zero_lim",  {3'b0, at_limit_s}, 4'h1);
    chk("wrap_zero_cnt", cnt_bin_w, 4'hF);
    chk("wrap_zero_wrap", {3'b0, wrap_p_w}, 4'h1);

    // Async reset mid-count and mid-stream; last sample before reset is 0000
    idle_inputs();
    en = 1'b1; up_dn = 1'b1; gin_vld = 1'b1; gray_in = 4'h3;
    tick();
    gray_in = 4'h0;
    tick();
    chk("pre_rst_cnt", cnt_bin_w, 4'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt_bin",  cnt_bin_w,  4'h0);
    chk("arst_cnt_gray", cnt_gray_w, 4'h0);
    chk("arst_dec_vld",  {3'b0, dec_vld_w},  4'h0);
    chk("arst_step_err", {3'b0, step_err_w}, 4'h0);
    chk("arst_dec_bin",  dec_bin_w,  4'h0);
    chk("arst_sat_cnt",  cnt_bin_s,  4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0; gray_in = 4'hF; gin_vld = 1'b1;
    tick();
    chk("post_rst_dec_bin",  dec_bin_w, 4'hA);
    chk("post_rst_dec_vld",  {3'b0, dec_vld_w},  4'h1);
    chk("post_rst_step_err", {3'b0, step_err_w}, 4'h0);
    // Repeated identical sample is legal
    tick();
    chk("repeat_step_err", {3'b0, step_err_w}, 4'h0);
    gin_vld = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
